// File: rtl/rle_pkg.sv
// rtl/rle_pkg.sv - shared widths, state encoding and byte-lane helpers for the rle codec
package rle_pkg;

    localparam int RUN_W  = 8;
    localparam int WORD_W = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_RDW,
        S_PROC,
        S_WR,
        S_FLUSH,
        S_DONE
    } state_e;

    function automatic logic [7:0] get_byte(input logic [WORD_W-1:0] word, input logic [1:0] lane);
        return word[{lane, 3'b000} +: 8];
    endfunction

    function automatic logic [WORD_W-1:0] put_byte(input logic [WORD_W-1:0] word,
                                                   input logic [1:0]        lane,
                                                   input logic [7:0]        b);
        logic [WORD_W-1:0] w;
        w = word;
        w[{lane, 3'b000} +: 8] = b;
        return w;
    endfunction

endpackage

// File: rtl/rle_word_packer.sv
// rtl/rle_word_packer.sv - packs output bytes little-endian into 32-bit words
// Flushing clears the buffer, so unused lanes of a partial word read back as zero.
module rle_word_packer
    import rle_pkg::*;
#(
    parameter int SIZE_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear_i,
    input  logic              push_i,
    input  logic [7:0]        byte_i,
    input  logic              flush_i,
    output logic              word_valid_o,
    output logic              empty_o,
    output logic [WORD_W-1:0] word_data_o,
    output logic [SIZE_W-1:0] byte_cnt_o
);

    logic [WORD_W-1:0] buf_q, buf_d;
    logic [2:0]        fill_q, fill_d;
    logic [SIZE_W-1:0] cnt_q, cnt_d;

    always_comb begin
        buf_d  = buf_q;
        fill_d = fill_q;
        cnt_d  = cnt_q;
        if (clear_i) begin
            buf_d  = '0;
            fill_d = '0;
            cnt_d  = '0;
        end else if (flush_i) begin
            buf_d  = '0;
            fill_d = '0;
        end else if (push_i) begin
            buf_d  = put_byte(buf_q, fill_q[1:0], byte_i);
            fill_d = fill_q + 3'd1;
            cnt_d  = cnt_q + SIZE_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_q  <= '0;
            fill_q <= '0;
            cnt_q  <= '0;
        end else begin
            buf_q  <= buf_d;
            fill_q <= fill_d;
            cnt_q  <= cnt_d;
        end
    end

    assign word_valid_o = fill_q[2];
    assign empty_o      = (fill_q == 3'd0);
    assign word_data_o  = buf_q;
    assign byte_cnt_o   = cnt_q;

endmodule

// File: rtl/rle_codec.sv
// rtl/rle_codec.sv - run-length encoder/decoder working on a word SRAM through port A
// One source byte per PROC cycle; an emitted pair stalls one cycle for its symbol byte.
module rle_codec
    import rle_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int SIZE_W  = 32,
    parameter int MAX_RUN = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [SIZE_W-1:0] src_size,
    input  logic [ADDR_W-1:0] dst_addr,
    output logic [SIZE_W-1:0] dst_size,
    output logic              done,
    output logic              err,
    output logic              port_A_clk,
    output logic [ADDR_W-1:0] port_A_addr,
    output logic              port_A_we,
    output logic [WORD_W-1:0] port_A_data_in,
    input  logic [WORD_W-1:0] port_A_data_out
);

    localparam logic [RUN_W-1:0] MAX_CNT = RUN_W'(MAX_RUN);

    state_e            state_q, state_d;
    logic              mode_q, mode_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [SIZE_W-1:0] size_q, size_d;
    logic [SIZE_W-1:0] idx_q, idx_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic              word_vld_q, word_vld_d;
    logic [RUN_W-1:0]  run_cnt_q, run_cnt_d;
    logic [7:0]        run_sym_q, run_sym_d;
    logic              pend_q, pend_d;
    logic [7:0]        pend_sym_q, pend_sym_d;
    logic              phase_q, phase_d;
    logic              err_q, err_d;
    logic              done_q, done_d;

    logic              pk_clear, pk_push, pk_flush, pk_full, pk_empty;
    logic [7:0]        pk_byte;
    logic [WORD_W-1:0] pk_word;
    logic              start_acc;
    logic [7:0]        cur_byte;

    rle_word_packer #(.SIZE_W(SIZE_W)) u_packer (
        .clk          (clk),
        .reset        (reset),
        .clear_i      (pk_clear),
        .push_i       (pk_push),
        .byte_i       (pk_byte),
        .flush_i      (pk_flush),
        .word_valid_o (pk_full),
        .empty_o      (pk_empty),
        .word_data_o  (pk_word),
        .byte_cnt_o   (dst_size)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            mode_q     <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            size_q     <= '0;
            idx_q      <= '0;
            word_q     <= '0;
            word_vld_q <= 1'b0;
            run_cnt_q  <= '0;
            run_sym_q  <= '0;
            pend_q     <= 1'b0;
            pend_sym_q <= '0;
            phase_q    <= 1'b0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            size_q     <= size_d;
            idx_q      <= idx_d;
            word_q     <= word_d;
            word_vld_q <= word_vld_d;
            run_cnt_q  <= run_cnt_d;
            run_sym_q  <= run_sym_d;
            pend_q     <= pend_d;
            pend_sym_q <= pend_sym_d;
            phase_q    <= phase_d;
            err_q      <= err_d;
            done_q     <= done_d;
        end
    end

    // run_cnt_q doubles as the current encode run length and the remaining decode expansion.
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        size_d     = size_q;
        idx_d      = idx_q;
        word_d     = word_q;
        word_vld_d = word_vld_q;
        run_cnt_d  = run_cnt_q;
        run_sym_d  = run_sym_q;
        pend_d     = pend_q;
        pend_sym_d = pend_sym_q;
        phase_d    = phase_q;
        err_d      = err_q;
        pk_clear   = 1'b0;
        pk_push    = 1'b0;
        pk_byte    = '0;
        start_acc  = 1'b0;
        cur_byte   = get_byte(word_q, idx_q[1:0]);
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    start_acc  = 1'b1;
                    pk_clear   = 1'b1;
                    mode_d     = mode;
                    rd_ptr_d   = src_addr;
                    wr_ptr_d   = dst_addr;
                    size_d     = src_size;
                    idx_d      = '0;
                    word_vld_d = 1'b0;
                    run_cnt_d  = '0;
                    pend_d     = 1'b0;
                    phase_d    = 1'b0;
                    err_d      = 1'b0;
                    state_d    = (src_size == '0) ? S_DONE : S_RD;
                end
            end
            S_RD: begin
                rd_ptr_d = rd_ptr_q + ADDR_W'(4);
                state_d  = S_RDW;
            end
            S_RDW: begin
                word_d     = port_A_data_out;
                word_vld_d = 1'b1;
                state_d    = S_PROC;
            end
            S_WR: begin
                wr_ptr_d = wr_ptr_q + ADDR_W'(4);
                state_d  = S_PROC;
            end
            S_FLUSH: begin
                if (!pk_empty) wr_ptr_d = wr_ptr_q + ADDR_W'(4);
                state_d = S_DONE;
            end
            S_PROC: begin
                if (pk_full) begin
                    state_d = S_WR;
                end else if (pend_q) begin
                    pk_push = 1'b1;
                    pk_byte = pend_sym_q;
                    pend_d  = 1'b0;
                end else if (mode_q && !phase_q && run_cnt_q != '0) begin
                    pk_push   = 1'b1;
                    pk_byte   = run_sym_q;
                    run_cnt_d = run_cnt_q - RUN_W'(1);
                end else if (idx_q == size_q) begin
                    if (!mode_q && run_cnt_q != '0) begin
                        pk_push    = 1'b1;
                        pk_byte    = run_cnt_q;
                        pend_d     = 1'b1;
                        pend_sym_d = run_sym_q;
                        run_cnt_d  = '0;
                    end else begin
                        if (mode_q && phase_q) err_d = 1'b1;
                        state_d = S_FLUSH;
                    end
                end else if (!word_vld_q) begin
                    state_d = S_RD;
                end else begin
                    idx_d = idx_q + SIZE_W'(1);
                    if (idx_q[1:0] == 2'd3) word_vld_d = 1'b0;
                    if (!mode_q) begin
                        if (run_cnt_q == '0) begin
                            run_cnt_d = RUN_W'(1);
                            run_sym_d = cur_byte;
                        end else if (cur_byte == run_sym_q && run_cnt_q < MAX_CNT) begin
                            run_cnt_d = run_cnt_q + RUN_W'(1);
                        end else begin
                            pk_push    = 1'b1;
                            pk_byte    = run_cnt_q;
                            pend_d     = 1'b1;
                            pend_sym_d = run_sym_q;
                            run_cnt_d  = RUN_W'(1);
                            run_sym_d  = cur_byte;
                        end
                    end else if (!phase_q) begin
                        if (cur_byte == 8'd0) begin
                            err_d   = 1'b1;
                            state_d = S_FLUSH;
                        end else begin
                            run_cnt_d = cur_byte;
                            phase_d   = 1'b1;
                        end
                    end else begin
                        run_sym_d = cur_byte;
                        phase_d   = 1'b0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        done_d = (state_d == S_DONE) && !start_acc;
    end

    always_comb begin
        port_A_addr    = '0;
        port_A_we      = 1'b0;
        port_A_data_in = '0;
        pk_flush       = 1'b0;
        unique case (state_q)
            S_RD: port_A_addr = rd_ptr_q;
            S_WR: begin
                port_A_addr    = wr_ptr_q;
                port_A_we      = 1'b1;
                port_A_data_in = pk_word;
                pk_flush       = 1'b1;
            end
            S_FLUSH: begin
                if (!pk_empty) begin
                    port_A_addr    = wr_ptr_q;
                    port_A_we      = 1'b1;
                    port_A_data_in = pk_word;
                    pk_flush       = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign port_A_clk = clk;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_rle_codec.sv
// tb/tb_rle_codec.sv - scoreboard bench for rle_codec with a byte-queue reference model
module tb_rle_codec;

    localparam int ADDR_W  = 16;
    localparam int SIZE_W  = 32;
    localparam int MAX_RUN = 255;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        int dst_size;
        bit err;
        int nwr;
        int wr_base;
        int nwords;
    } exp_t;
    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wexp_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              mode;
    logic [ADDR_W-1:0] src_addr;
    logic [SIZE_W-1:0] src_size;
    logic [ADDR_W-1:0] dst_addr;
    logic [SIZE_W-1:0] dst_size;
    logic              done;
    logic              err;
    logic              port_A_clk;
    logic [ADDR_W-1:0] port_A_addr;
    logic              port_A_we;
    logic [31:0]       port_A_data_in;
    logic [31:0]       port_A_data_out = '0;

    logic [31:0] mem [0:(1<<(ADDR_W-2))-1];
    int          wr_count = 0;
    int          checks   = 0;
    int          errors   = 0;
    exp_t        exp_q[$];
    wexp_t       wexp_q[$];

    always #5 clk = ~clk;

    rle_codec #(.ADDR_W(ADDR_W), .SIZE_W(SIZE_W), .MAX_RUN(MAX_RUN)) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .mode            (mode),
        .src_addr        (src_addr),
        .src_size        (src_size),
        .dst_addr        (dst_addr),
        .dst_size        (dst_size),
        .done            (done),
        .err             (err),
        .port_A_clk      (port_A_clk),
        .port_A_addr     (port_A_addr),
        .port_A_we       (port_A_we),
        .port_A_data_in  (port_A_data_in),
        .port_A_data_out (port_A_data_out)
    );

    always @(posedge port_A_clk) begin
        if (port_A_we) begin
            mem[port_A_addr[ADDR_W-1:2]] = port_A_data_in;
            wr_count++;
        end
        port_A_data_out <= mem[port_A_addr[ADDR_W-1:2]];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: whole-message run-length rules on byte queues.
    task automatic model_encode(input bq_t src, output bq_t out);
        int i;
        int len;
        out = {};
        i = 0;
        while (i < src.size()) begin
            len = 1;
            while (i + len < src.size() && src[i+len] == src[i] && len < MAX_RUN) len++;
            out.push_back(8'(len));
            out.push_back(src[i]);
            i += len;
        end
    endtask

    task automatic model_decode(input bq_t src, output bq_t out, output bit e);
        out = {};
        e   = 1'b0;
        for (int i = 0; i + 1 < src.size(); i += 2) begin
            if (src[i] == 8'd0) begin
                e = 1'b1;
                break;
            end
            repeat (int'(src[i])) out.push_back(src[i+1]);
        end
        if (src.size() % 2 == 1) e = 1'b1;
    endtask

    function automatic logic [31:0] pack_word(input bq_t b, input int w);
        logic [31:0] v;
        v = '0;
        for (int l = 0; l < 4; l++)
            if (4*w + l < b.size()) v[8*l +: 8] = b[4*w + l];
        return v;
    endfunction

    task automatic mem_put(input logic [ADDR_W-1:0] a, input logic [31:0] v);
        mem[a[ADDR_W-1:2]] = v;
    endtask

    function automatic logic [31:0] mem_get(input logic [ADDR_W-1:0] a);
        return mem[a[ADDR_W-1:2]];
    endfunction

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL done_timeout: done=%0b after %0d cycles, required 1", done, n);
        end
    endtask

    task automatic run_job(input bit m, input logic [ADDR_W-1:0] sa, input logic [ADDR_W-1:0] da,
                           input bq_t src, input bit poke);
        bq_t   out;
        bit    e;
        exp_t  x;
        wexp_t y;
        int    nw;
        for (int w = 0; w < (src.size() + 3) / 4; w++)
            mem_put(sa + ADDR_W'(4*w), pack_word(src, w));
        if (m) model_decode(src, out, e);
        else begin
            model_encode(src, out);
            e = 1'b0;
        end
        nw = (out.size() + 3) / 4;
        for (int w = 0; w <= nw; w++) mem_put(da + ADDR_W'(4*w), 32'hDEADBEEF);
        x.dst_size = out.size();
        x.err      = e;
        x.nwr      = nw;
        x.wr_base  = wr_count;
        x.nwords   = nw + 1;
        for (int w = 0; w <= nw; w++) begin
            y.addr = da + ADDR_W'(4*w);
            y.data = (w < nw) ? pack_word(out, w) : 32'hDEADBEEF;
            wexp_q.push_back(y);
        end
        exp_q.push_back(x);
        @(negedge clk);
        start    = 1'b1;
        mode     = m;
        src_addr = sa;
        src_size = SIZE_W'(src.size());
        dst_addr = da;
        @(negedge clk);
        start = 1'b0;
        if (poke) begin
            repeat (4) @(negedge clk);
            start    = 1'b1;
            mode     = ~m;
            src_size = '0;
            src_addr = 16'h0040;
            dst_addr = 16'h0080;
            @(negedge clk);
            start = 1'b0;
        end
        wait_done((src.size() == 0) ? 2 : 4 * (src.size() + out.size()) + 100);
        repeat (2) @(negedge clk);
    endtask

    initial begin : monitor
        bit    done_prev;
        exp_t  x;
        wexp_t y;
        done_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (done && !done_prev) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: done=1 with no job outstanding, required 0");
                end else begin
                    x = exp_q.pop_front();
                    check("dst_size", 64'(dst_size), 64'(x.dst_size));
                    check("err", 64'(err), 64'(x.err));
                    check("write_count", 64'(wr_count - x.wr_base), 64'(x.nwr));
                    for (int w = 0; w < x.nwords; w++) begin
                        y = wexp_q.pop_front();
                        check("mem_word", 64'(mem_get(y.addr)), 64'(y.data));
                    end
                end
            end
            done_prev = done;
        end
    end

    initial begin : stimulus
        bq_t         s;
        logic [7:0]  enc_vec [8];
        logic [7:0]  b;
        int          n;
        int          snap;
        int          pick;
        logic [7:0]  c;

        reset = 1'b1; start = 1'b0; mode = 1'b0;
        src_addr = '0; src_size = '0; dst_addr = '0;
        repeat (3) @(negedge clk);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_dst_size", 64'(dst_size), 64'd0);
        check("rst_we", 64'(port_A_we), 64'd0);
        check("rst_addr", 64'(port_A_addr), 64'd0);
        check("rst_wdata", 64'(port_A_data_in), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        enc_vec = '{8'h41, 8'h41, 8'h41, 8'h42, 8'h42, 8'h42, 8'h42, 8'h43};
        s = {};
        foreach (enc_vec[i]) s.push_back(enc_vec[i]);
        run_job(1'b0, 16'h0000, 16'h00C8, s, 1'b0);
        check("enc_word0", 64'(mem_get(16'h00C8)), 64'h42044103);
        check("enc_word1", 64'(mem_get(16'h00CC)), 64'h00004301);
        check("enc_size", 64'(dst_size), 64'd6);

        s = {};
        repeat (300) s.push_back(8'h55);
        run_job(1'b0, 16'h1000, 16'h0400, s, 1'b0);
        check("split_word", 64'(mem_get(16'h0400)), 64'h552D55FF);
        check("split_size", 64'(dst_size), 64'd4);

        s = {};
        s.push_back(8'h03); s.push_back(8'h41); s.push_back(8'h04);
        s.push_back(8'h42); s.push_back(8'h01); s.push_back(8'h43);
        run_job(1'b1, 16'h00C8, 16'h0500, s, 1'b0);
        check("dec_word0", 64'(mem_get(16'h0500)), 64'h42414141);
        check("dec_word1", 64'(mem_get(16'h0504)), 64'h43424242);
        check("dec_size", 64'(dst_size), 64'd8);

        s = {};
        s.push_back(8'h00); s.push_back(8'h41);
        run_job(1'b1, 16'h0600, 16'h0700, s, 1'b0);
        check("zero_cnt_err", 64'(err), 64'd1);
        check("zero_cnt_size", 64'(dst_size), 64'd0);

        s = {};
        s.push_back(8'h02); s.push_back(8'h41); s.push_back(8'h03);
        s.push_back(8'h42); s.push_back(8'h01);
        run_job(1'b1, 16'h0600, 16'h0700, s, 1'b0);
        check("odd_size_err", 64'(err), 64'd1);

        s = {};
        run_job(1'b0, 16'h0600, 16'h0700, s, 1'b0);
        run_job(1'b1, 16'h0600, 16'h0700, s, 1'b0);

        s = {};
        for (int i = 0; i < 40; i++) s.push_back((i % 3 == 0) ? 8'h11 : 8'h22);
        run_job(1'b0, 16'h1000, 16'h0800, s, 1'b1);
        repeat (10) @(negedge clk);
        check("busy_single_done", 64'(done), 64'd1);

        s = {};
        for (int i = 0; i < 200; i++) s.push_back(8'(i));
        for (int w = 0; w < 50; w++) mem_put(16'h1000 + ADDR_W'(4*w), pack_word(s, w));
        @(negedge clk);
        start = 1'b1; mode = 1'b0; src_addr = 16'h1000; src_size = 200; dst_addr = 16'h2000;
        @(negedge clk);
        start = 1'b0;
        repeat (30) @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrst_we", 64'(port_A_we), 64'd0);
        check("midrst_addr", 64'(port_A_addr), 64'd0);
        check("midrst_wdata", 64'(port_A_data_in), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_dst_size", 64'(dst_size), 64'd0);
        snap = wr_count;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        check("midrst_no_writes", 64'(wr_count - snap), 64'd0);
        check("midrst_idle_done", 64'(done), 64'd0);

        for (int j = 0; j < 24; j++) begin
            s = {};
            if (j % 2 == 0) begin
                n = $urandom_range(1, 64);
                b = 8'($urandom);
                for (int i = 0; i < n; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        pick = $urandom_range(0, 2);
                        b = (pick == 0) ? 8'h00 : (pick == 1) ? 8'hFF : 8'($urandom);
                    end
                    s.push_back(b);
                end
                run_job(1'b0, 16'h8000, 16'h4000 + ADDR_W'(256 * $urandom_range(0, 15)), s, 1'b0);
            end else begin
                n = $urandom_range(1, 12);
                for (int p = 0; p < n; p++) begin
                    c = 8'($urandom_range(1, 8));
                    if ($urandom_range(0, 15) == 0) c = 8'h00;
                    s.push_back(c);
                    s.push_back(8'($urandom));
                end
                if ($urandom_range(0, 7) == 0) s.push_back(8'($urandom_range(1, 5)));
                run_job(1'b1, 16'h8000, 16'h4000 + ADDR_W'(256 * $urandom_range(0, 15)), s, 1'b0);
            end
        end

        repeat (5) @(negedge clk);
        check("jobs_retired", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rle_codec.md
# rle_codec

Parametrised run-length codec that sits beside the word-addressed dual-port SRAM, as the rle block does. It either compresses a byte message into (count, symbol) pairs or expands such pairs back into bytes, selected per job by `mode`. It reads and writes the SRAM only through port A, one 32-bit word at a time. Over the plain encoder it adds configurable maximum run length, a decode mode, an error flag and parametrised address width.

## Interface
- `ADDR_W`, 16: width of `port_A_addr` (byte address).
- `SIZE_W`, 32: width of size inputs and outputs.
- `MAX_RUN`, 255: longest run in one pair; legal range 1..255. The count field is always 8 bits.

Ports:
- `clk`  in  1  sole clock; `port_A_clk` is driven from it.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  job request; sampled only in IDLE or DONE.
- `mode`  in  1  0 = encode, 1 = decode; sampled with `start`.
- `src_addr`  in  ADDR_W  source byte address; word aligned.
- `src_size`  in  SIZE_W  source length in bytes.
- `dst_addr`  in  ADDR_W  destination byte address; word aligned.
- `dst_size`  out  SIZE_W  bytes written; valid while `done`.
- `done`  out  1  job finished; level signal.
- `err`  out  1  job aborted on malformed input; valid while `done`.
- `port_A_clk`  out  1  equals `clk`.
- `port_A_addr`  out  ADDR_W  word-aligned byte address.
- `port_A_we`  out  1  1 = write, 0 = read.
- `port_A_data_in`  out  32  write data to the SRAM.
- `port_A_data_out`  in  32  read data from the SRAM.

## Operation
- **Byte order** is little-endian: stream byte i is in word (base + 4·⌊i/4⌋), bits [8(i%4)+7 : 8(i%4)].
- **Pair format**: count byte first, then symbol byte.
- **Encode**:
  - Runs of identical bytes are emitted as (count, symbol).
  - Runs longer than MAX_RUN are split into MAX_RUN chunks plus a remainder.
  - `dst_size` = 2 × pairs.
- **Decode**:
  - Pairs are read from source and each symbol is written `count` times.
  - `dst_size` = Σ counts.
  - A count of 0, or an odd `src_size`, aborts the job with `err`=1. Bytes already written stay in memory, and `dst_size` reports them.
- **Buffering**: output bytes are packed into a 32-bit buffer and written when full. A partial final word is written with unused lanes set to 0.
- **States**:
  - IDLE: waits for `start`.
  - RD: drives a read address.
  - RDW: waits one cycle for read data.
  - PROC: consumes one source byte per cycle.
  - WR: writes one full output word.
  - FLUSH: writes the partial final word and any pending pair.
  - DONE: reports the result.
- **Transitions**:
  - IDLE or DONE → RD on `start` with `src_size`≠0.
  - IDLE or DONE → DONE on `start` with `src_size`=0. There are no memory accesses and `dst_size`=0.
  - PROC → WR when the output buffer fills, then back to PROC.
  - PROC → RD when the current source word is exhausted.
  - PROC → FLUSH after the last source byte.
  - FLUSH → DONE.
- **Busy**: `start` is ignored in every other state.
- **Arithmetic**:
  - The run counter is 8 bits and never exceeds MAX_RUN.
  - Byte counters are SIZE_W bits.
  - Address arithmetic wraps modulo 2^ADDR_W.

## Timing
- **Reset values**:
  - state IDLE.
  - `done`=0, `err`=0, `dst_size`=0.
  - `port_A_we`=0, `port_A_addr`=0, `port_A_data_in`=0.
- **Reset mid-job**: the job stops immediately, with no further SRAM write after reset asserts.
- **Read latency**: 1 cycle. Data for an address presented in cycle N is valid on `port_A_data_out` in cycle N+1.
- **Writes**: `port_A_we`=1 for exactly one cycle per word. Address and data are stable in that cycle.
- **`done`**:
  - Rises in the cycle after the last write.
  - Stays high until the next accepted `start`, and drops in the cycle after that `start`.
  - `dst_size` and `err` are stable while `done`=1.
- **Throughput**: at most 1 source byte per cycle in PROC. Decode expansion writes at most 1 output byte per cycle.
- **Start on the `done` cycle**: restart is accepted.

## Structure
- Package `rle_pkg` holds:
  - the state enum;
  - `RUN_W`=8;
  - `WORD_W`=32;
  - the byte-lane extract/insert functions.
- One sub-module, `rle_word_packer`, accumulates output bytes into words. Its interface is push byte, flush, word-valid and word-data; its byte-count output feeds `dst_size`.

## Test plan
- **Encode**: source bytes 41 41 41 42 42 42 42 43, `mode`=0, `dst_addr`=0xC8.
  - Expect `dst_size`=6.
  - Expect word[0xC8]=0x42044103 and word[0xCC]=0x00004301.
  - Expect `err`=0.
- **Run split**: 300 × 0x55, MAX_RUN=255.
  - Expect pairs (FF,55)(2D,55).
  - Expect `dst_size`=4 and the single word 0x552D55FF.
- **Decode round trip**: decode the output of the first test with `src_size`=6.
  - Expect the original 8 bytes: words 0x42414141 and 0x43424242.
  - Expect `dst_size`=8.
- **Malformed decode**:
  - Pair (00,41) → `done`=1, `err`=1, `dst_size`=0.
  - `src_size`=5 → `err`=1.
- **Zero-length job**: `src_size`=0 → `done` within 2 cycles, no `port_A_we` pulse, `dst_size`=0.
- **Control**:
  - Assert `reset` mid-job → outputs return to their reset values and no further writes occur.
  - `start` pulsed while busy is ignored; the first job's result is unchanged.
